// File: rtl/secure_write_gate.sv
// rtl/secure_write_gate.sv - key-sequenced write gate with timed unlock window and violation fuse
module secure_write_gate #(
  parameter logic [31:0] KEY0     = 32'hA5A5_0001,
  parameter logic [31:0] KEY1     = 32'h5A5A_0002,
  parameter int          TIMEOUT  = 16,
  parameter int          MAX_FAIL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_kind,
  input  logic        req_priv,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        unlocked,
  output logic        violation,
  output logic        fused,
  output logic [7:0]  viol_count
);

  typedef enum logic [1:0] {LOCKED, ARMED, UNLOCKED, FUSED} state_t;

  localparam logic [1:0] KIND_DATA   = 2'b00;
  localparam logic [1:0] KIND_KEY    = 2'b01;
  localparam logic [1:0] KIND_RELOCK = 2'b10;
  localparam logic [7:0] TIMEOUT_W   = 8'(TIMEOUT);
  localparam logic [7:0] MAX_FAIL_W  = 8'(MAX_FAIL);

  state_t      state_q, state_d, base;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  count_d;
  logic        xfer, do_write, do_viol;

  assign xfer = req_valid & req_ready;

  always_comb begin
    state_d  = state_q;
    base     = state_q;
    timer_d  = 8'd0;
    count_d  = viol_count;
    do_write = 1'b0;
    do_viol  = 1'b0;

    // An expired window behaves exactly like LOCKED for this cycle's transfer.
    if (state_q == UNLOCKED && timer_q == 8'd0) begin
      base    = LOCKED;
      state_d = LOCKED;
    end

    if (xfer) begin
      case (base)
        LOCKED: begin
          if (req_kind == KIND_KEY && req_priv && req_data == KEY0)
            state_d = ARMED;
          else if (req_kind != KIND_RELOCK)
            do_viol = 1'b1;
        end
        ARMED: begin
          if (req_kind == KIND_KEY && req_priv && req_data == KEY1) begin
            state_d = UNLOCKED;
          end else begin
            state_d = LOCKED;
            do_viol = (req_kind != KIND_RELOCK);
          end
        end
        UNLOCKED: begin
          if (req_kind == KIND_DATA && req_priv)
            do_write = 1'b1;
          else if (req_kind == KIND_RELOCK)
            state_d = LOCKED;
          else
            do_viol = 1'b1;
        end
        FUSED: do_viol = 1'b1;
      endcase
    end

    if (do_viol) begin
      if (viol_count != 8'hFF)
        count_d = viol_count + 8'd1;
      if (count_d == MAX_FAIL_W)
        state_d = FUSED;
    end

    if (state_d == UNLOCKED)
      timer_d = (state_q == UNLOCKED) ? timer_q - 8'd1 : TIMEOUT_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCKED;
      timer_q    <= 8'd0;
      req_ready  <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= 32'd0;
      unlocked   <= 1'b0;
      violation  <= 1'b0;
      fused      <= 1'b0;
      viol_count <= 8'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      req_ready  <= 1'b1;
      wr_en      <= do_write;
      if (do_write)
        wr_data  <= req_data;
      unlocked   <= (state_d == UNLOCKED);
      violation  <= do_viol;
      fused      <= (state_d == FUSED);
      viol_count <= count_d;
    end
  end

endmodule

// File: tb/tb_secure_write_gate.sv
// tb/tb_secure_write_gate.sv - directed and randomized checks of secure_write_gate against a window/deadline model
module tb_secure_write_gate;

  localparam logic [31:0] KEY0 = 32'hA5A5_0001;
  localparam logic [31:0] KEY1 = 32'h5A5A_0002;
  localparam int TIMEOUT  = 16;
  localparam int MAX_FAIL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_kind = 2'b00;
  logic        req_priv = 1'b0;
  logic [31:0] req_data = 32'd0;
  logic        req_ready, wr_en, unlocked, violation, fused;
  logic [31:0] wr_data;
  logic [7:0]  viol_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: mode 0 locked, 1 armed, 2 unlocked, 3 fused; window closes at cycle m_deadline.
  int          m_mode = 0;
  int          m_deadline = 0;
  int          m_count = 0;
  int          cyc = 0;
  bit          m_ready = 0;
  bit          m_wr_en = 0;
  bit          m_viol = 0;
  logic [31:0] m_wr_data = 32'd0;

  always #5 clk = ~clk;

  secure_write_gate #(.KEY0(KEY0), .KEY1(KEY1), .TIMEOUT(TIMEOUT), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kind(req_kind), .req_priv(req_priv),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .wr_data(wr_data),
    .unlocked(unlocked), .violation(violation), .fused(fused), .viol_count(viol_count)
  );

  task automatic step(input bit r, input bit v, input logic [1:0] k, input bit p, input logic [31:0] d);
    int eff, nxt;
    bit wr, vi;
    @(negedge clk);
    rst = r; req_valid = v; req_kind = k; req_priv = p; req_data = d;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_count = 0; m_ready = 0; m_wr_en = 0; m_viol = 0; m_wr_data = 32'd0;
    end else begin
      wr = 0; vi = 0;
      eff = m_mode; nxt = m_mode;
      if (m_mode == 2 && cyc >= m_deadline) begin eff = 0; nxt = 0; end
      if (v && m_ready) begin
        if (eff == 0) begin
          if (k == 2'b01 && p && d == KEY0) nxt = 1;
          else if (k != 2'b10) vi = 1;
        end else if (eff == 1) begin
          if (k == 2'b01 && p && d == KEY1) begin nxt = 2; m_deadline = cyc + 1 + TIMEOUT; end
          else begin nxt = 0; vi = (k != 2'b10); end
        end else if (eff == 2) begin
          if (k == 2'b00 && p) wr = 1;
          else if (k == 2'b10) nxt = 0;
          else vi = 1;
        end else vi = 1;
      end
      if (vi) begin
        if (m_count < 255) m_count++;
        if (m_count == MAX_FAIL) nxt = 3;
      end
      m_mode = nxt; m_ready = 1; m_wr_en = wr; m_viol = vi;
      if (wr) m_wr_data = d;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 32'd0);
  endtask

  task automatic do_reset();
    step(1, 1, 2'b01, 1, KEY0);
    step(1, 0, 2'b00, 0, 32'd0);
    idle(1);
  endtask

  task automatic do_unlock();
    step(0, 1, 2'b01, 1, KEY0);
    step(0, 1, 2'b01, 1, KEY1);
  endtask

  task automatic test_reset();
    step(1, 1, 2'b00, 1, 32'h1111_2222);
    step(1, 1, 2'b00, 1, 32'h1111_2222);
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    tests_run++; if (wr_en !== 1'b0 || wr_data !== 32'd0) begin tests_failed++; $display("FAIL reset_wr: got %b/%h expected 0/0", wr_en, wr_data); end
    tests_run++; if ({unlocked, violation, fused} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {unlocked, violation, fused}); end
    tests_run++; if (viol_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", viol_count); end
    idle(1);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset: got %b expected 1", req_ready); end
  endtask

  task automatic test_unlock_write();
    do_reset();
    do_unlock();
    tests_run++; if (unlocked !== 1'b1) begin tests_failed++; $display("FAIL unlock_flag: got %b expected 1", unlocked); end
    step(0, 1, 2'b00, 1, 32'hDEAD_BEEF);
    tests_run++; if (wr_en !== 1'b1 || wr_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL unlock_write: got %b/%h expected 1/deadbeef", wr_en, wr_data); end
    tests_run++; if (viol_count !== 8'd0) begin tests_failed++; $display("FAIL unlock_count: got %0d expected 0", viol_count); end
    idle(1);
    tests_run++; if (wr_en !== 1'b0 || wr_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_hold: got %b/%h expected 0/deadbeef", wr_en, wr_data); end
  endtask

  task automatic test_timeout();
    do_reset();
    do_unlock();
    idle(TIMEOUT);
    step(0, 1, 2'b00, 1, 32'h1234_5678);
    tests_run++; if (wr_en !== 1'b0 || violation !== 1'b1) begin tests_failed++; $display("FAIL timeout_reject: got wr_en %b viol %b expected 0 1", wr_en, violation); end
    tests_run++; if (unlocked !== 1'b0 || viol_count !== 8'd1) begin tests_failed++; $display("FAIL timeout_state: got %b/%0d expected 0/1", unlocked, viol_count); end
  endtask

  task automatic test_window_edge();
    do_reset();
    do_unlock();
    idle(TIMEOUT - 1);
    step(0, 1, 2'b00, 1, 32'hCAFE_0001);
    tests_run++; if (wr_en !== 1'b1 || wr_data !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL last_window_cycle: got %b/%h expected 1/cafe0001", wr_en, wr_data); end
  endtask

  task automatic test_bad_key();
    do_reset();
    step(0, 1, 2'b01, 1, KEY0);
    step(0, 1, 2'b01, 1, 32'h0000_0000);
    tests_run++; if (violation !== 1'b1 || unlocked !== 1'b0) begin tests_failed++; $display("FAIL bad_key: got viol %b unl %b expected 1 0", violation, unlocked); end
    step(0, 1, 2'b01, 1, KEY1);
    tests_run++; if (violation !== 1'b1 || unlocked !== 1'b0 || viol_count !== 8'd2) begin tests_failed++; $display("FAIL bad_key_relocked: got %b/%b/%0d expected 1/0/2", violation, unlocked, viol_count); end
  endtask

  task automatic test_fuse();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 0, 32'h0BAD_0000 + i);
    tests_run++; if (fused !== 1'b1 || viol_count !== 8'd4) begin tests_failed++; $display("FAIL fuse_trip: got %b/%0d expected 1/4", fused, viol_count); end
    do_unlock();
    step(0, 1, 2'b00, 1, 32'h5555_AAAA);
    tests_run++; if (wr_en !== 1'b0 || viol_count !== 8'd7 || fused !== 1'b1) begin tests_failed++; $display("FAIL fused_drop: got %b/%0d/%b expected 0/7/1", wr_en, viol_count, fused); end
  endtask

  task automatic test_rst_override();
    do_reset();
    do_unlock();
    step(1, 1, 2'b00, 1, 32'h7777_7777);
    tests_run++; if (wr_en !== 1'b0 || unlocked !== 1'b0 || viol_count !== 8'd0 || req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL rst_override: got %b/%b/%0d/%b expected 0/0/0/0", wr_en, unlocked, viol_count, req_ready); end
  endtask

  task automatic test_relock_at_one();
    do_reset();
    do_unlock();
    idle(TIMEOUT - 1);
    step(0, 1, 2'b10, 1, 32'd0);
    tests_run++; if (unlocked !== 1'b0 || violation !== 1'b0) begin tests_failed++; $display("FAIL relock: got %b/%b expected 0/0", unlocked, violation); end
    step(0, 1, 2'b00, 1, 32'h9999_0000);
    tests_run++; if (wr_en !== 1'b0 || violation !== 1'b1 || viol_count !== 8'd1) begin tests_failed++; $display("FAIL write_after_relock: got %b/%b/%0d expected 0/1/1", wr_en, violation, viol_count); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0: d = KEY0;
        1: d = KEY1;
        default: d = $urandom;
      endcase
      step($urandom_range(0, 99) < 4, $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 8, d);
      tests_run++;
      if (req_ready !== m_ready || wr_en !== m_wr_en || violation !== m_viol ||
          wr_data !== m_wr_data || unlocked !== (m_mode == 2) || fused !== (m_mode == 3) ||
          viol_count !== 8'(m_count)) begin
        tests_failed++;
        $display("FAIL random[%0d]: got rdy%b wr%b %h v%b u%b f%b c%0d expected rdy%b wr%b %h v%b u%b f%b c%0d",
                 i, req_ready, wr_en, wr_data, violation, unlocked, fused, viol_count,
                 m_ready, m_wr_en, m_wr_data, m_viol, m_mode == 2, m_mode == 3, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock_write();
    test_timeout();
    test_window_edge();
    test_bad_key();
    test_fuse();
    test_rst_override();
    test_relock_at_one();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
